// File: rtl/capture_sequencer_if.sv
// FIFO and host-read handshake bundle for capture_sequencer.
// The sequencer drives the o_* signals through the master modport; the FIFO
// and host side drive the i_* signals through the slave modport.
interface capture_sequencer_if;
    logic o_fifo_aclr;
    logic o_fifo_wrreq;
    logic o_fifo_rdreq;
    logic o_rd_valid;
    logic i_fifo_full;
    logic i_fifo_empty;
    logic i_rd_req;

    modport master (
        output o_fifo_aclr, o_fifo_wrreq, o_fifo_rdreq, o_rd_valid,
        input  i_fifo_full, i_fifo_empty, i_rd_req
    );

    modport slave (
        input  o_fifo_aclr, o_fifo_wrreq, o_fifo_rdreq, o_rd_valid,
        output i_fifo_full, i_fifo_empty, i_rd_req
    );
endinterface

// File: rtl/capture_sequencer.sv
// Acquisition controller for the logic analyzer: clears the {time, data}
// FIFO, arms, gates pin-change writes during the trigger window, stops on
// limit / overflow / trigger end, then lets the host drain the FIFO.
// Optional feature: define CAPTURE_TIMEOUT_EN to add an armed-state timeout
// (TIMEOUT_CYC parameter and the sticky o_timeout output).
module capture_sequencer #(
    parameter int CNT_W  = 32,
    parameter int RD_LAT = 1
`ifdef CAPTURE_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 50000000
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_arm,
    input  logic                 i_abort,
    input  logic                 i_trig,
    input  logic                 i_save,
    input  logic                 i_limit_en,
    input  logic [CNT_W-1:0]     i_limit,
    capture_sequencer_if.master  bus,
    output logic                 o_run,
    output logic                 o_timer_run,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [2:0]           o_state,
    output logic [CNT_W-1:0]     o_count
`ifdef CAPTURE_TIMEOUT_EN
    , output logic               o_timeout
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ARMED   = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              arm_q;
    logic              arm_rise;
    logic [CNT_W-1:0]  limit_q;
    logic [CNT_W-1:0]  count_inc;
    logic              limit_hit;
    logic              wr, rd;
    logic              ovf_set;
    logic              tmo_set;
    logic [RD_LAT-1:0] rd_pipe;

    assign arm_rise  = i_arm & ~arm_q;
    // Saturating increment: the counter sticks at all-ones.
    assign count_inc = (o_count == '1) ? o_count : o_count + CNT_W'(1);
    // A latched limit of zero means unlimited.
    assign limit_hit = i_limit_en && (limit_q != '0) && (count_inc == limit_q);

`ifdef CAPTURE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Armed-state cycle counter; held at zero outside ARMED so it restarts on entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if (state_q == ARMED) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

    // Next-state and output decode; abort overrides every other event.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d     = state_q;
        wr          = 1'b0;
        rd          = 1'b0;
        ovf_set     = 1'b0;
        tmo_set     = 1'b0;
        o_run       = 1'b0;
        o_timer_run = 1'b0;
        o_done      = 1'b0;
        bus.o_fifo_aclr = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_rise) state_d = CLEAR;
            end
            CLEAR: begin
                bus.o_fifo_aclr = 1'b1;
                state_d         = ARMED;
            end
            ARMED: begin
                o_run = 1'b1;
                if (i_trig) begin
                    state_d = CAPTURE;
                end
`ifdef CAPTURE_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_d = DRAIN;
                    tmo_set = 1'b1;
                end
`endif
            end
            CAPTURE: begin
                o_run       = 1'b1;
                o_timer_run = 1'b1;
                wr          = i_save & ~bus.i_fifo_full;
                if (i_save && bus.i_fifo_full) begin
                    ovf_set = 1'b1;
                    state_d = DRAIN;
                end else if (wr && limit_hit) begin
                    state_d = DRAIN;
                end else if (!i_trig) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                o_done = 1'b1;
                rd     = bus.i_rd_req & ~bus.i_fifo_empty;
                if (arm_rise) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
        if (i_abort) begin
            state_d = IDLE;
            wr      = 1'b0;
            rd      = 1'b0;
            ovf_set = 1'b0;
            tmo_set = 1'b0;
        end
    end

    assign bus.o_fifo_wrreq = wr;
    assign bus.o_fifo_rdreq = rd;
    assign bus.o_rd_valid   = rd_pipe[RD_LAT-1];
    assign o_state          = state_q;

    // State, arm edge detector, sample counter and sticky flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            arm_q      <= 1'b0;
            limit_q    <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
            o_timeout  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            arm_q   <= i_arm;
            // CLEAR is only ever entered from an accepted arm edge: start a fresh capture.
            if (state_d == CLEAR) begin
                limit_q    <= i_limit;
                o_count    <= '0;
                o_overflow <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
                o_timeout  <= 1'b0;
`endif
            end else begin
                if (wr) o_count <= count_inc;
                if (ovf_set) o_overflow <= 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
                if (tmo_set) o_timeout <= 1'b1;
`endif
            end
        end
    end

`ifndef CAPTURE_TIMEOUT_EN
    logic unused_tmo;
    assign unused_tmo = tmo_set;
`endif

    // Read-valid delay line matching the FIFO q latency; not cleared by abort
    // so reads already issued still deliver their valid pulse.
    if (RD_LAT > 1) begin : g_rd_pipe
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) rd_pipe <= '0;
            else          rd_pipe <= {rd_pipe[RD_LAT-2:0], rd};
        end
    end else begin : g_rd_single
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) rd_pipe <= '0;
            else          rd_pipe <= rd;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer with a small FIFO occupancy model
// and queues of expected write counts and expected read-valid cycles.
module tb_capture_sequencer;
    localparam int CNT_W  = 32;
    localparam int RD_LAT = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             arm = 1'b0, abort = 1'b0, trig = 1'b0, save = 1'b0;
    logic             limit_en = 1'b0, force_full = 1'b0, rd_req = 1'b0;
    logic [CNT_W-1:0] limit = '0;
    logic             run, timer_run, done, overflow;
    logic [2:0]       state;
    logic [CNT_W-1:0] count;
`ifdef CAPTURE_TIMEOUT_EN
    logic             timeout;
`endif

    capture_sequencer_if bus();

    int fifo_cnt = 0;
    assign bus.i_fifo_full  = force_full;
    assign bus.i_fifo_empty = (fifo_cnt == 0);
    assign bus.i_rd_req     = rd_req;

    always #5 clk = ~clk;

    capture_sequencer #(
        .CNT_W (CNT_W),
        .RD_LAT(RD_LAT)
`ifdef CAPTURE_TIMEOUT_EN
        , .TIMEOUT_CYC(10)
`endif
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_arm      (arm),
        .i_abort    (abort),
        .i_trig     (trig),
        .i_save     (save),
        .i_limit_en (limit_en),
        .i_limit    (limit),
        .bus        (bus),
        .o_run      (run),
        .o_timer_run(timer_run),
        .o_done     (done),
        .o_overflow (overflow),
        .o_state    (state),
        .o_count    (count)
`ifdef CAPTURE_TIMEOUT_EN
        , .o_timeout(timeout)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int aclr_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    int exp_count = 0;
    int exp_wr_q[$];
    int exp_valid_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO occupancy model driven by the FIFO-side strobes.
    always @(posedge clk) begin
        if (bus.o_fifo_aclr) fifo_cnt <= 0;
        else fifo_cnt <= fifo_cnt + int'(bus.o_fifo_wrreq) - int'(bus.o_fifo_rdreq);
    end

    // Output monitor: pops scoreboard entries when the DUT produces writes and valids.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_fifo_aclr) aclr_cnt++;
            if (bus.o_fifo_rdreq) rd_cnt++;
            if (bus.o_fifo_wrreq) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else check("wr_count_before", count, exp_wr_q.pop_front());
            end
            if (bus.o_rd_valid) begin
                if (exp_valid_q.size() == 0) check("valid_unexpected", 1, 0);
                else check("valid_cycle", cyc, exp_valid_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_seq();
        arm = 1'b1;
        step();
        check("arm_clear_state", state, 1);
        check("arm_aclr", bus.o_fifo_aclr, 1);
        arm = 1'b0;
        step();
        check("armed_state", state, 2);
        check("armed_run", run, 1);
        check("armed_aclr_off", bus.o_fifo_aclr, 0);
    endtask

    // Drive one save in the current cycle and record whether a write is expected.
    task automatic save_once(input logic exp_wr);
        save = 1'b1;
        #1;
        check("wrreq", bus.o_fifo_wrreq, exp_wr);
        if (exp_wr) begin
            exp_wr_q.push_back(exp_count);
            exp_count++;
        end
    endtask

    initial begin
        int n;
        int ewords;
        logic cap;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_outs", {run, timer_run, done, overflow, bus.o_fifo_aclr,
                           bus.o_fifo_wrreq, bus.o_fifo_rdreq, bus.o_rd_valid}, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        step();
        check("idle_after_rst", state, 0);

        // Limit of 20 with 25 saves
        limit_en = 1'b1;
        limit    = 20;
        aclr_cnt = 0;
        wr_cnt   = 0;
        arm_seq();
        check("aclr_once", aclr_cnt, 1);
        trig = 1'b1;
        step();
        check("capture_state", state, 3);
        check("timer_run", timer_run, 1);
        exp_count = 0;
        cap = 1'b1;
        for (int i = 0; i < 25; i++) begin
            save_once(cap && exp_count < 20);
            if (exp_count == 20) cap = 1'b0;
            step();
            save = 1'b0;
            step();
        end
        check("limit_wr_cnt", wr_cnt, 20);
        check("limit_count", count, 20);
        check("limit_state", state, 4);
        check("limit_done", done, 1);
        check("limit_run", run, 0);
        check("limit_aclr_total", aclr_cnt, 1);
        trig = 1'b0;

        // Overflow on the third save
        limit_en = 1'b0;
        arm_seq();
        check("arm_count_clr", count, 0);
        trig = 1'b1;
        step();
        exp_count = 0;
        for (int i = 0; i < 2; i++) begin
            save_once(1'b1);
            step();
            save = 1'b0;
            step();
        end
        force_full = 1'b1;
        save_once(1'b0);
        step();
        save = 1'b0;
        force_full = 1'b0;
        check("ovf_state", state, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 2);
        trig = 1'b0;

        // Save written in the same cycle the trigger falls
        arm_seq();
        check("ovf_cleared", overflow, 0);
        trig = 1'b1;
        step();
        exp_count = 0;
        for (int i = 0; i < 2; i++) begin
            save_once(1'b1);
            step();
            save = 1'b0;
            step();
        end
        trig = 1'b0;
        save_once(1'b1);
        step();
        save = 1'b0;
        check("trigend_state", state, 4);
        check("trigend_count", count, 3);

        // Drain three words with five read requests
        rd_cnt = 0;
        ewords = 3;
        for (int i = 0; i < 5; i++) begin
            rd_req = 1'b1;
            #1;
            check("rdreq", bus.o_fifo_rdreq, ewords > 0);
            if (ewords > 0) begin
                exp_valid_q.push_back(cyc + RD_LAT);
                ewords--;
            end
            step();
            rd_req = 1'b0;
            step();
        end
        repeat (RD_LAT + 1) step();
        check("rd_cnt", rd_cnt, 3);
        check("valid_all_seen", exp_valid_q.size(), 0);

        // Abort from ARMED and from DRAIN
        arm_seq();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_armed_state", state, 0);
        check("abort_armed_run", run, 0);
        arm_seq();
        trig = 1'b1;
        step();
        exp_count = 0;
        save_once(1'b1);
        step();
        save = 1'b0;
        trig = 1'b0;
        step();
        check("pre_abort_drain", state, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_drain_state", state, 0);
        check("abort_drain_done", done, 0);
        check("abort_count_hold", count, 1);

        // Limit enabled with a zero limit: unlimited
        limit_en = 1'b1;
        limit    = 0;
        arm_seq();
        trig = 1'b1;
        step();
        exp_count = 0;
        wr_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            save_once(1'b1);
            step();
        end
        save = 1'b0;
        check("unlim_count", count, 100);
        check("unlim_wr_cnt", wr_cnt, 100);
        check("unlim_state", state, 3);
        trig = 1'b0;
        step();
        check("unlim_drain", state, 4);

`ifdef CAPTURE_TIMEOUT_EN
        // Armed timeout
        arm_seq();
        check("tmo_clear", timeout, 0);
        n = 0;
        while (state != 3'd4 && n < 50) begin
            step();
            n++;
        end
        check("tmo_cycles", n, 10);
        check("tmo_flag", timeout, 1);
`endif

        // Asynchronous reset mid-capture at count 5
        limit_en = 1'b0;
        arm_seq();
        trig = 1'b1;
        step();
        exp_count = 0;
        for (int i = 0; i < 5; i++) begin
            save_once(1'b1);
            step();
            save = 1'b0;
            step();
        end
        check("pre_rst_count", count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_state", state, 0);
        check("midrst_outs", {run, timer_run, done, overflow, bus.o_fifo_aclr,
                              bus.o_fifo_wrreq, bus.o_fifo_rdreq, bus.o_rd_valid}, 0);
        trig = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_count", count, 0);
        check("post_rst_state", state, 0);
        check("wr_q_drained", exp_wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
